seq_divider10: RTL

- Sequential unsigned restoring divider, the inverse of the team's 10-bit carry-lookahead adder.
- Produces quotient and remainder of two WIDTH-bit operands, one quotient bit per clock.
- Each iteration is a trial subtraction, implemented as an add of the two's-complement divisor through a lookahead-style adder path.
- Sits beside the adder in the arithmetic library.
- Start/busy/done handshake for use by a simple controller.

---
 rtl/seq_divider10.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seq_divider10.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// The trial subtraction is performed as an add of the two's-complement
// divisor through a generate/propagate carry path, mirroring the 10-bit
// carry-lookahead adder this block sits beside in the arithmetic library.
// Handshake: start is accepted in IDLE or DONE; busy covers RUN; done is a
// one-cycle pulse with quotient/remainder/div_by_zero held until next result.
module seq_divider10 #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dshift;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dsor;     // divisor captured at start
  // The restored partial remainder is always < divisor, so its bit WIDTH is
  // always zero; only the low WIDTH bits are stored. The trial arithmetic
  // below is carried out the full WIDTH+1 bits wide.
  logic [WIDTH-1:0] prem;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   gen;
  logic [WIDTH:0]   prop;
  logic [WIDTH:0]   trial;
  logic             carry;
  logic             qbit;
  logic [WIDTH-1:0] next_prem;
  logic [WIDTH-1:0] next_shift;

  // Trial subtraction shifted - {0,divisor} as shifted + ~{0,divisor} + 1 via generate/propagate carries
  always_comb begin
    // NOTE: every variable written here is assigned on every pass through the
    // block, so no latch can be inferred; carry is a running temporary.
    shifted = {prem, dshift[WIDTH-1]};
    addend  = ~{1'b0, dsor};
    gen     = shifted & addend;
    prop    = shifted ^ addend;
    trial   = '0;
    carry   = 1'b1;
    for (int i = 0; i <= WIDTH; i++) begin
      trial[i] = prop[i] ^ carry;
      carry    = gen[i] | (prop[i] & carry);
    end
    // Non-negative trial (MSB clear) means the divisor fits: keep it, quotient bit 1.
    qbit       = ~trial[WIDTH];
    next_prem  = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    next_shift = {dshift[WIDTH-2:0], qbit};
  end

  // Control FSM, iteration datapath and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dshift      <= '0;
      dsor        <= '0;
      prem        <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // updates from the values held before this edge regardless of order.
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            dshift <= dividend;
            dsor   <= divisor;
            prem   <= '0;
            count  <= '0;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          dshift <= next_shift;
          prem   <= next_prem;
          count  <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= next_shift;
            remainder   <= next_prem;
            div_by_zero <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
